sop_pos_sweep_checker: RTL and testbench

//  Downstream companion to the lab's 4-input SOP/POS gate modules. It drives all 2^N_IN

---
 rtl/sop_pos_sweep_checker.sv | 102 ++++++++++
 tb/tb_sop_pos_sweep_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_pos_sweep_checker.sv
// Sweeps every input combination through one combinational SOP/POS gate pair in ascending
// order, checks that both forms agree and records the SOP truth table and mismatch details.
module sop_pos_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sop_in,
    input  logic                  pos_in,
    output logic [N_IN-1:0]       vec,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_IN:0]         mismatch_cnt,
    output logic [N_IN-1:0]       first_fail,
    output logic                  first_fail_vld,
    output logic [(1<<N_IN)-1:0]  sop_table,
    output logic [1:0]            state_dbg
);

    // Handshake: start is a single-cycle request, accepted only in IDLE or DONE; while
    // busy=1 it is dropped without effect. There is no back-pressure on sop_in/pos_in,
    // which are sampled on the last cycle each vector is held.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};
    localparam logic [3:0]      SETTLE_VAL = 4'(SETTLE);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       differ;

    assign differ    = sop_in ^ pos_in;
    assign pass      = done && (mismatch_cnt == '0);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            settle_cnt     <= '0;
            vec            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            sop_table      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_DRIVE;
                        settle_cnt     <= SETTLE_VAL;
                        vec            <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        mismatch_cnt   <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                        sop_table      <= '0;
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        // Sample edge: the gate output has had SETTLE+1 cycles on this vector.
                        sop_table[vec] <= sop_in;
                        if (differ) begin
                            mismatch_cnt <= mismatch_cnt + 1'b1;
                            if (!first_fail_vld) begin
                                first_fail     <= vec;
                                first_fail_vld <= 1'b1;
                            end
                        end
                        if (vec != VEC_LAST) begin
                            vec        <= vec + 1'b1;
                            settle_cnt <= SETTLE_VAL;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sop_pos_sweep_checker.sv
// Directed bench for sop_pos_sweep_checker: two instances (SETTLE=0 and SETTLE=3), each fed
// by a selectable behavioural gate, checked against hand-computed truth tables.
module tb_sop_pos_sweep_checker;

    logic        clk;
    logic        rst_n;
    int          errors;
    int          checks;

    logic        start0, sop0, pos0, busy0, done0, pass0, ffv0;
    logic [3:0]  vec0, ff0;
    logic [4:0]  mcnt0;
    logic [15:0] tbl0;
    logic [1:0]  st0;
    int          mode0;

    logic        start1, sop1, pos1, busy1, done1, pass1, ffv1;
    logic [3:0]  vec1, ff1;
    logic [4:0]  mcnt1;
    logic [15:0] tbl1;
    logic [1:0]  st1;
    int          mode1;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    sop_pos_sweep_checker #(.N_IN(4), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sop_in(sop0), .pos_in(pos0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mcnt0),
        .first_fail(ff0), .first_fail_vld(ffv0), .sop_table(tbl0), .state_dbg(st0)
    );

    sop_pos_sweep_checker #(.N_IN(4), .SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sop_in(sop1), .pos_in(pos1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mcnt1),
        .first_fail(ff1), .first_fail_vld(ffv1), .sop_table(tbl1), .state_dbg(st1)
    );

    // Gate under check: 1 = a|bd|bc vs (a|b)(a|c|d); 2 = a|~b&c vs ~b&(a|c); 3 = SOP stuck 0
    function automatic logic [1:0] gate(input int m, input logic [3:0] v);
        logic a, b, c, d, s, p;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        s = 1'b0;
        p = 1'b0;
        case (m)
            1: begin s = a | (b & d) | (b & c); p = (a | b) & (a | c | d); end
            2: begin s = a | (~b & c);          p = ~b & (a | c);          end
            3: begin s = 1'b0;                  p = (a | b) & (a | c | d); end
            default: begin s = 1'b0; p = 1'b0; end
        endcase
        return {s, p};
    endfunction

    always_comb {sop0, pos0} = gate(mode0, vec0);
    always_comb {sop1, pos1} = gate(mode1, vec1);

    // driver: pulse start, then follow the sweep cycle by cycle until busy drops
    task automatic run_sweep(input int sel, input int extra_at, output int cyc,
                             output int seq_err, output logic clr_ok, output logic to);
        int         settle;
        logic       b;
        logic [3:0] v;
        settle  = (sel == 1) ? 3 : 0;
        cyc     = 0;
        seq_err = 0;
        clr_ok  = 1'b0;
        to      = 1'b1;
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            b = (sel == 1) ? busy1 : busy0;
            v = (sel == 1) ? vec1 : vec0;
            if (!b) begin
                to = 1'b0;
                break;
            end
            cyc++;
            if (v !== 4'((cyc - 1) / (settle + 1))) seq_err++;
            if (cyc == 1)
                clr_ok = (sel == 1)
                    ? (mcnt1 == 5'd0 && ffv1 == 1'b0 && ff1 == 4'd0 && tbl1 == 16'd0 && done1 == 1'b0)
                    : (mcnt0 == 5'd0 && ffv0 == 1'b0 && ff0 == 4'd0 && tbl0 == 16'd0 && done0 == 1'b0);
            if (cyc == extra_at) begin
                if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0  = 1;
        mode1  = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({vec0, busy0, done0, pass0, mcnt0, ff0, ffv0, tbl0} !== 35'd0) begin
            errors++;
            $display("FAIL reset_dut0 got=%h want=0", {vec0, busy0, done0, pass0, mcnt0, ff0, ffv0, tbl0});
        end
        checks++;
        if ({vec1, busy1, done1, pass1, mcnt1, ff1, ffv1, tbl1} !== 35'd0) begin
            errors++;
            $display("FAIL reset_dut1 got=%h want=0", {vec1, busy1, done1, pass1, mcnt1, ff1, ffv1, tbl1});
        end
        checks++;
        if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", st0); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++; $display("FAIL idle_no_start got busy=%b done=%b want 0 0", busy0, done0);
        end
    endtask

    task automatic test_agree();
        int cyc, se; logic clr, to;
        mode0 = 1;
        run_sweep(0, 0, cyc, se, clr, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL agree_timeout got=%b want=0", to); end
        checks++; if (cyc != 16) begin errors++; $display("FAIL agree_busy_cycles got=%0d want=16", cyc); end
        checks++; if (se != 0) begin errors++; $display("FAIL agree_vec_order got=%0d bad want=0", se); end
        checks++;
        if ({done0, pass0, mcnt0, ffv0} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
            errors++; $display("FAIL agree_status got done=%b pass=%b cnt=%0d vld=%b want 1 1 0 0", done0, pass0, mcnt0, ffv0);
        end
        checks++; if (tbl0 !== 16'hFFE0) begin errors++; $display("FAIL agree_table got=%h want=ffe0", tbl0); end
        checks++; if (vec0 !== 4'hF) begin errors++; $display("FAIL agree_vec_hold got=%h want=f", vec0); end
        checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL agree_state got=%0d want=2", st0); end
        repeat (5) @(negedge clk);
        checks++;
        if ({done0, busy0, tbl0, mcnt0} !== {1'b1, 1'b0, 16'hFFE0, 5'd0}) begin
            errors++; $display("FAIL done_stable got done=%b busy=%b tbl=%h cnt=%0d", done0, busy0, tbl0, mcnt0);
        end
    endtask

    task automatic test_mismatch();
        int cyc, se; logic clr, to;
        mode0 = 2;
        run_sweep(0, 0, cyc, se, clr, to);
        checks++; if (cyc != 16 || to) begin errors++; $display("FAIL mm_busy_cycles got=%0d to=%b want=16", cyc, to); end
        checks++; if (mcnt0 !== 5'd4) begin errors++; $display("FAIL mm_count got=%0d want=4", mcnt0); end
        checks++;
        if ({ffv0, ff0} !== {1'b1, 4'hC}) begin
            errors++; $display("FAIL mm_first got vld=%b vec=%h want 1 c", ffv0, ff0);
        end
        checks++; if ({done0, pass0} !== 2'b10) begin errors++; $display("FAIL mm_pass got done=%b pass=%b want 1 0", done0, pass0); end
        checks++; if (tbl0 !== 16'hFF0C) begin errors++; $display("FAIL mm_table got=%h want=ff0c", tbl0); end
    endtask

    task automatic test_settle();
        int cyc, se; logic clr, to;
        mode1 = 1;
        run_sweep(1, 0, cyc, se, clr, to);
        checks++; if (cyc != 64 || to) begin errors++; $display("FAIL settle_busy_cycles got=%0d to=%b want=64", cyc, to); end
        checks++; if (se != 0) begin errors++; $display("FAIL settle_vec_hold got=%0d bad want=0", se); end
        checks++;
        if ({done1, pass1, mcnt1, ffv1, tbl1} !== {1'b1, 1'b1, 5'd0, 1'b0, 16'hFFE0}) begin
            errors++; $display("FAIL settle_result got done=%b pass=%b cnt=%0d vld=%b tbl=%h", done1, pass1, mcnt1, ffv1, tbl1);
        end
    endtask

    task automatic test_start_busy();
        int cyc, se; logic clr, to;
        mode0 = 1;
        run_sweep(0, 5, cyc, se, clr, to);
        checks++; if (cyc != 16 || to) begin errors++; $display("FAIL busy_start_cycles got=%0d to=%b want=16", cyc, to); end
        checks++; if (se != 0) begin errors++; $display("FAIL busy_start_order got=%0d bad want=0", se); end
        checks++;
        if ({pass0, tbl0} !== {1'b1, 16'hFFE0}) begin
            errors++; $display("FAIL busy_start_result got pass=%b tbl=%h want 1 ffe0", pass0, tbl0);
        end
    endtask

    task automatic test_start_on_last();
        int cyc, se; logic clr, to;
        mode0 = 1;
        run_sweep(0, 16, cyc, se, clr, to);
        checks++; if (cyc != 16 || to) begin errors++; $display("FAIL last_start_cycles got=%0d to=%b want=16", cyc, to); end
        @(negedge clk);
        checks++;
        if ({busy0, done0, pass0, vec0} !== {1'b0, 1'b1, 1'b1, 4'hF}) begin
            errors++; $display("FAIL last_start_ignored got busy=%b done=%b pass=%b vec=%h", busy0, done0, pass0, vec0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, se; logic clr, to; logic hit;
        mode0 = 1;
        hit = 1'b0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (vec0 == 4'd7 && busy0) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach got=0 want=1"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vec0, busy0, done0, pass0, mcnt0, ff0, ffv0, tbl0} !== 35'd0) begin
            errors++; $display("FAIL rst_mid_clear got=%h want=0", {vec0, busy0, done0, pass0, mcnt0, ff0, ffv0, tbl0});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_mid_no_restart got busy=%b want=0", busy0); end
        run_sweep(0, 0, cyc, se, clr, to);
        checks++;
        if (cyc != 16 || se != 0 || {pass0, tbl0} !== {1'b1, 16'hFFE0}) begin
            errors++; $display("FAIL rst_mid_rerun got cyc=%0d bad=%0d pass=%b tbl=%h want 16 0 1 ffe0", cyc, se, pass0, tbl0);
        end
    endtask

    task automatic test_forced_sop();
        int cyc, se; logic clr, to;
        mode0 = 3;
        run_sweep(0, 0, cyc, se, clr, to);
        checks++;
        if ({mcnt0, ffv0, ff0, tbl0, pass0} !== {5'd11, 1'b1, 4'h5, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL forced_result got cnt=%0d vld=%b ff=%h tbl=%h pass=%b want 11 1 5 0 0", mcnt0, ffv0, ff0, tbl0, pass0);
        end
        run_sweep(0, 0, cyc, se, clr, to);
        checks++; if (clr !== 1'b1) begin errors++; $display("FAIL forced_restart_clear got=%b want=1", clr); end
        checks++;
        if ({mcnt0, ffv0, ff0, done0} !== {5'd11, 1'b1, 4'h5, 1'b1}) begin
            errors++; $display("FAIL forced_reaccum got cnt=%0d vld=%b ff=%h done=%b want 11 1 5 1", mcnt0, ffv0, ff0, done0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_agree();
        test_mismatch();
        test_settle();
        test_start_busy();
        test_start_on_last();
        test_reset_mid();
        test_forced_sop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
